// File: rtl/fnd_scan_ctrl.sv
//------------------------------------------------------------------------------
// fnd_scan_ctrl : multiplexed 7-segment scan controller with dead-time and
// frame-synchronous double buffering. Optional macro: LEADING_ZERO_SUPPRESS_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int DEAD_CYC   = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   i_digits,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  input  logic                      i_load,
  output logic [3:0]                o_sel,
  output logic [NUM_DIGITS-1:0]     o_com,
  output logic                      o_busy,
  output logic                      o_frame
);

  localparam int MAX_CYC = (SLOT_CYC > DEAD_CYC) ? SLOT_CYC : DEAD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [3:0]                sel_q, sel_d;
  logic [4*NUM_DIGITS-1:0]   shd_q, shd_d;
  logic [NUM_DIGITS-1:0]     shb_q, shb_d;
  logic [4*NUM_DIGITS-1:0]   pdig_q, pdig_d;
  logic [NUM_DIGITS-1:0]     pblk_q, pblk_d;
  logic                      pend_q, pend_d;

  logic                      first_dead;
  logic                      apply;
  logic                      slot_end;
  logic [NUM_DIGITS-1:0]     supp;

`ifdef LEADING_ZERO_SUPPRESS_EN
  // hi_clear[k]: every digit above k is zero or blanked in the pending buffer.
  logic [NUM_DIGITS-1:0] hi_clear;
  assign hi_clear[NUM_DIGITS-1] = 1'b1;
  assign supp[0]                = 1'b0;

  for (genvar k = NUM_DIGITS - 2; k >= 0; k--) begin : g_hi_clear
    assign hi_clear[k] = hi_clear[k+1] &
                         ((pdig_q[4*(k+1) +: 4] == 4'd0) | pblk_q[k+1]);
  end

  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_supp
    assign supp[k] = hi_clear[k] & (pdig_q[4*k +: 4] == 4'd0);
  end
`else
  assign supp = '0;
`endif

  assign first_dead = (state_q == ST_DEAD) && (cnt_q == '0);
  assign apply      = first_dead && (idx_q == '0) && pend_q;
  assign slot_end   = (state_q == ST_DRIVE) && (cnt_q == SLOT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sel_d   = sel_q;
    shd_d   = shd_q;
    shb_d   = shb_q;
    pdig_d  = pdig_q;
    pblk_d  = pblk_q;
    pend_d  = pend_q;

    case (state_q)
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = ST_DEAD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_DEAD;
        cnt_d   = '0;
      end
    endcase

    if (apply) begin
      shd_d  = pdig_q;
      shb_d  = pblk_q | supp;
      pend_d = 1'b0;
    end

    // Digit code is latched from the post-apply shadow so a new frame shows new data.
    if (first_dead) begin
      sel_d = shd_d[{idx_q, 2'b00} +: 4];
    end

    // A load on the apply cycle lands in pending and survives to the next frame.
    if (i_load) begin
      pdig_d = i_digits;
      pblk_d = i_blank;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DEAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= 4'd0;
      shd_q   <= '0;
      shb_q   <= '1;
      pdig_q  <= '0;
      pblk_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      shd_q   <= shd_d;
      shb_q   <= shb_d;
      pdig_q  <= pdig_d;
      pblk_q  <= pblk_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    o_com = '1;
    if ((state_q == ST_DRIVE) && !shb_q[idx_q]) begin
      o_com[idx_q] = 1'b0;
    end
  end

  assign o_sel   = sel_q;
  assign o_busy  = pend_q;
  assign o_frame = slot_end && (idx_q == IDX_LAST);

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (4 digits, 4-cycle slot, 1-cycle dead time).
`default_nettype none

module tb_fnd_scan_ctrl;

  localparam int N     = 4;
  localparam int SLOT  = 4;
  localparam int DEAD  = 1;
  localparam int PER   = DEAD + SLOT;
  localparam int FRAME = N * PER;

  logic            clk;
  logic            rst_n;
  logic [4*N-1:0]  i_digits;
  logic [N-1:0]    i_blank;
  logic            i_load;
  logic [3:0]      o_sel;
  logic [N-1:0]    o_com;
  logic            o_busy;
  logic            o_frame;

  fnd_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYC(SLOT), .DEAD_CYC(DEAD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_digits (i_digits),
    .i_blank  (i_blank),
    .i_load   (i_load),
    .o_sel    (o_sel),
    .o_com    (o_com),
    .o_busy   (o_busy),
    .o_frame  (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] com;
    logic         frame;
    logic         busy;
    logic [3:0]   sel;
    logic         sel_vld;
  } exp_t;

  exp_t exp_q[$];

  int vectors;
  int errors;

  // Reference state: frame position of the current cycle plus buffer contents.
  int          m_pos;
  logic [15:0] m_shd;
  logic [3:0]  m_shb;
  logic [15:0] m_pd;
  logic [3:0]  m_pb;
  logic        m_pend;

  function automatic logic [3:0] supp_mask(input logic [15:0] d, input logic [3:0] b);
    logic [3:0] m;
    logic       lead;
    m = 4'b0000;
`ifdef LEADING_ZERO_SUPPRESS_EN
    lead = 1'b1;
    for (int k = N - 1; k >= 1; k--) begin
      if (lead && d[4*k +: 4] == 4'd0) m[k] = 1'b1;
      lead = lead && (d[4*k +: 4] == 4'd0 || b[k]);
    end
`else
    lead = 1'b0;
    if (lead) m = d[3:0] | b;
`endif
    return m;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_shd  = '0;
    m_shb  = '1;
    m_pd   = '0;
    m_pb   = '0;
    m_pend = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict, compare at negedge, advance model at posedge.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] b);
    exp_t e, g;
    int   slot, off;
    logic apply;
    i_load   = ld;
    i_digits = d;
    i_blank  = b;
    slot = m_pos / PER;
    off  = m_pos % PER;
    e.com     = '1;
    e.sel_vld = (off >= DEAD);
    if (e.sel_vld && !m_shb[slot]) e.com[slot] = 1'b0;
    e.frame   = (m_pos == FRAME - 1);
    e.busy    = m_pend;
    e.sel     = m_shd[4*slot +: 4];
    exp_q.push_back(e);

    @(negedge clk);
    g = exp_q.pop_front();
    vectors++;
    if (o_com !== g.com) begin
      errors++;
      $display("FAIL com pos=%0d got=%b exp=%b", m_pos, o_com, g.com);
    end
    vectors++;
    if (o_frame !== g.frame) begin
      errors++;
      $display("FAIL frame pos=%0d got=%b exp=%b", m_pos, o_frame, g.frame);
    end
    vectors++;
    if (o_busy !== g.busy) begin
      errors++;
      $display("FAIL busy pos=%0d got=%b exp=%b", m_pos, o_busy, g.busy);
    end
    if (g.sel_vld) begin
      vectors++;
      if (o_sel !== g.sel) begin
        errors++;
        $display("FAIL sel pos=%0d got=%h exp=%h", m_pos, o_sel, g.sel);
      end
    end

    @(posedge clk);
    apply = (m_pos == 0) && m_pend;
    if (apply) begin
      m_shd  = m_pd;
      m_shb  = m_pb | supp_mask(m_pd, m_pb);
      m_pend = 1'b0;
    end
    if (ld) begin
      m_pd   = d;
      m_pb   = b;
      m_pend = 1'b1;
    end
    m_pos = (m_pos + 1) % FRAME;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 4'h0);
  endtask

  task automatic idle_to(input int pos);
    for (int i = 0; i < FRAME && m_pos != pos; i++) cycle(1'b0, 16'h0000, 4'h0);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    i_load   = 1'b0;
    i_digits = '0;
    i_blank  = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (o_com !== 4'hF || o_sel !== 4'h0 || o_busy !== 1'b0 || o_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got com=%b sel=%h busy=%b frame=%b exp com=1111 sel=0 busy=0 frame=0",
               o_com, o_sel, o_busy, o_frame);
    end
    rst_n = 1'b1;
    model_reset();
    idle(3 * FRAME);
  endtask

  task automatic test_basic_scan();
    cycle(1'b1, 16'h4321, 4'h0);
    idle_to(0);
    idle(2 * FRAME);
  endtask

  task automatic test_tear_free();
    idle_to(7);
    cycle(1'b1, 16'hABCD, 4'h0);
    idle(2 * FRAME);
  endtask

  task automatic test_double_load();
    idle_to(3);
    cycle(1'b1, 16'h9999, 4'h0);
    idle(5);
    cycle(1'b1, 16'h0005, 4'h0);
    idle_to(0);
    idle(FRAME);
  endtask

  task automatic test_collision();
    idle_to(12);
    cycle(1'b1, 16'h1234, 4'h0);
    idle_to(0);
    cycle(1'b1, 16'h5678, 4'h0);
    idle(2 * FRAME);
  endtask

  task automatic test_blank();
    cycle(1'b1, 16'h8765, 4'b1010);
    idle_to(0);
    idle(2 * FRAME);
  endtask

  task automatic test_zero_suppress();
    cycle(1'b1, 16'h0070, 4'h0);
    idle_to(0);
    idle(2 * FRAME);
    cycle(1'b1, 16'h0300, 4'b1000);
    idle_to(0);
    idle(FRAME);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 16'h2468, 4'h0);
    idle_to(0);
    idle_to(2);
    cycle(1'b1, 16'h1111, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_com !== 4'hF || o_busy !== 1'b0 || o_sel !== 4'h0) begin
      errors++;
      $display("FAIL async_reset got com=%b busy=%b sel=%h exp com=1111 busy=0 sel=0",
               o_com, o_busy, o_sel);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(FRAME + 3);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    model_reset();
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_double_load();
    test_collision();
    test_blank();
    test_zero_suppress();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
